// File: rtl/arch_pkg.sv
// Shared instruction-format definitions for the 32-bit core: field positions,
// instruction type codes, immediate-width codes and ID-stage FSM states.
package arch_pkg;

  localparam int unsigned XLEN_W    = 32;
  localparam int unsigned FIELD_W   = 5;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned EXT_SRC_W = 2;

  // Field bit positions inside the instruction word
  localparam int unsigned FUNC_HI  = 31;
  localparam int unsigned FUNC_LO  = 27;
  localparam int unsigned RS1_HI   = 26;
  localparam int unsigned RS1_LO   = 22;
  localparam int unsigned RD_HI    = 21;
  localparam int unsigned RD_LO    = 17;
  localparam int unsigned RS2_HI   = 16;
  localparam int unsigned RS2_LO   = 12;
  localparam int unsigned SA_HI    = 16;
  localparam int unsigned SA_LO    = 12;
  localparam int unsigned IMM14_HI = 16;
  localparam int unsigned IMM14_LO = 3;
  localparam int unsigned IMM24_HI = 26;
  localparam int unsigned IMM24_LO = 3;
  localparam int unsigned TYPE_HI  = 2;
  localparam int unsigned TYPE_LO  = 1;
  localparam int unsigned STOP_BIT = 0;

  localparam logic [FIELD_W-1:0] FUNC_ANDI = 5'd0;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_R = 2'b00,
    TYPE_I = 2'b01,
    TYPE_J = 2'b10,
    TYPE_S = 2'b11
  } instr_type_e;

  typedef enum logic [EXT_SRC_W-1:0] {
    EXT_5  = 2'd0,
    EXT_14 = 2'd1,
    EXT_24 = 2'd2
  } ext_src_e;

  // Immediate bundle handed to the sign_extender
  typedef struct packed {
    logic [XLEN_W-1:0]    ext_in;
    logic [EXT_SRC_W-1:0] ext_src;
    logic                 sign_op;
  } imm_info_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } id_state_e;

endpackage

// File: rtl/id_stage_reg_imm_align.sv
// imm_align: combinational immediate extraction. Right-aligns the raw immediate
// of an instruction word and reports its width and extension mode.
//   instr    in  32  instruction word
//   ext_in   out 32  right-aligned raw immediate (upper bits zero)
//   ext_src  out 2   0 = 5-bit, 1 = 14-bit, 2 = 24-bit
//   sign_op  out 1   1 = sign-extend, 0 = zero-extend
module imm_align
  import arch_pkg::*;
#(
  parameter logic [FIELD_W-1:0] UNS_FUNC = FUNC_ANDI
) (
  input  logic [XLEN_W-1:0]    instr,
  output logic [XLEN_W-1:0]    ext_in,
  output logic [EXT_SRC_W-1:0] ext_src,
  output logic                 sign_op
);

  imm_info_t info;

  // Select immediate by instruction type
  always_comb begin
    info.ext_in  = '0;
    info.ext_src = EXT_5;
    info.sign_op = 1'b1;
    case (instr[TYPE_HI:TYPE_LO])
      TYPE_I: begin
        info.ext_in  = XLEN_W'(instr[IMM14_HI:IMM14_LO]);
        info.ext_src = EXT_14;
        info.sign_op = (instr[FUNC_HI:FUNC_LO] != UNS_FUNC);
      end
      TYPE_J: begin
        info.ext_in  = XLEN_W'(instr[IMM24_HI:IMM24_LO]);
        info.ext_src = EXT_24;
        info.sign_op = 1'b1;
      end
      TYPE_S: begin
        // Shift amount is an unsigned 5-bit quantity
        info.ext_in  = XLEN_W'(instr[SA_HI:SA_LO]);
        info.ext_src = EXT_5;
        info.sign_op = 1'b0;
      end
      default: begin
        info.ext_in  = '0;
        info.ext_src = EXT_5;
        info.sign_op = 1'b1;
      end
    endcase
  end

  assign ext_in  = info.ext_in;
  assign ext_src = info.ext_src;
  assign sign_op = info.sign_op;

endmodule

// File: rtl/id_stage_reg.sv
// id_stage_reg: IF/ID pipeline register with field decode and halt control.
// Holds one fetched instruction behind a valid/ready handshake, decodes its
// fields combinationally from the held word, and blocks fetch after a stop-bit
// instruction until flush.
//   clk, reset_n            clock, async active-low reset
//   if_valid/if_ready       fetch handshake (if_ready combinational)
//   if_instr, if_pc         fetched word and its PC
//   flush                   kill held instruction, leave HALT
//   id_valid/id_ready       downstream handshake
//   id_pc, id_func, id_rs1, id_rd, id_rs2, id_type   decoded fields
//   ext_in, ext_src, sign_op                         immediate to sign_extender
//   halted                  stop-bit instruction accepted, fetch blocked
module id_stage_reg
  import arch_pkg::*;
#(
  parameter int unsigned        XLEN     = 32,
  parameter logic [FIELD_W-1:0] UNS_FUNC = FUNC_ANDI
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [XLEN-1:0]      if_instr,
  input  logic [XLEN-1:0]      if_pc,
  input  logic                 flush,
  input  logic                 id_ready,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_pc,
  output logic [FIELD_W-1:0]   id_func,
  output logic [FIELD_W-1:0]   id_rs1,
  output logic [FIELD_W-1:0]   id_rd,
  output logic [FIELD_W-1:0]   id_rs2,
  output logic [TYPE_W-1:0]    id_type,
  output logic [XLEN-1:0]      ext_in,
  output logic [EXT_SRC_W-1:0] ext_src,
  output logic                 sign_op,
  output logic                 halted
);

  id_state_e       state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            load;

  // Accept only while running, not flushing, and the slot is free or draining
  assign if_ready = (state_q == ST_RUN) & ~flush & (~valid_q | id_ready);
  assign load     = if_valid & if_ready;

  // Next-state: flush dominates, then load, then drain
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (load) begin
      instr_d = if_instr;
      pc_d    = if_pc;
      valid_d = 1'b1;
      if (if_instr[STOP_BIT]) state_d = ST_HALT;
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and holding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign halted   = (state_q == ST_HALT);
  assign id_func  = instr_q[FUNC_HI:FUNC_LO];
  assign id_rs1   = instr_q[RS1_HI:RS1_LO];
  assign id_rd    = instr_q[RD_HI:RD_LO];
  assign id_rs2   = instr_q[RS2_HI:RS2_LO];
  assign id_type  = instr_q[TYPE_HI:TYPE_LO];

  imm_align #(
    .UNS_FUNC (UNS_FUNC)
  ) u_imm_align (
    .instr   (instr_q),
    .ext_in  (ext_in),
    .ext_src (ext_src),
    .sign_op (sign_op)
  );

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg: driver models the stage at transaction
// level and queues expected decodes; a monitor pops and compares on every
// downstream handshake.
module tb_id_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  func;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [1:0]  typ;
    logic [31:0] ext;
    logic [1:0]  src;
    logic        sg;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid, if_ready, flush, id_ready, id_valid, sign_op, halted;
  logic [31:0] if_instr, if_pc, id_pc, ext_in;
  logic [4:0]  id_func, id_rs1, id_rd, id_rs2;
  logic [1:0]  id_type, ext_src;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];
  logic m_valid, m_halt;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  id_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_func(id_func), .id_rs1(id_rs1),
    .id_rd(id_rd), .id_rs2(id_rs2), .id_type(id_type), .ext_in(ext_in),
    .ext_src(ext_src), .sign_op(sign_op), .halted(halted)
  );

  // Expected decode from the format rules, using shifts and masks
  function automatic exp_t exp_of(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.func = 5'((w >> 27) & 32'h1F);
    e.rs1  = 5'((w >> 22) & 32'h1F);
    e.rd   = 5'((w >> 17) & 32'h1F);
    e.rs2  = 5'((w >> 12) & 32'h1F);
    e.typ  = 2'((w >> 1) & 32'h3);
    case (e.typ)
      2'd1: begin e.ext = (w >> 3) & 32'h3FFF;   e.src = 2'd1; e.sg = (e.func != 5'd0); end
      2'd2: begin e.ext = (w >> 3) & 32'hFF_FFFF; e.src = 2'd2; e.sg = 1'b1; end
      2'd3: begin e.ext = (w >> 12) & 32'h1F;    e.src = 2'd0; e.sg = 1'b0; end
      default: begin e.ext = 32'h0; e.src = 2'd0; e.sg = 1'b1; end
    endcase
    return e;
  endfunction

  // Downstream sign_extender behaviour
  function automatic logic [31:0] sext(input logic [31:0] v, input logic [1:0] src, input logic sg);
    int unsigned wd;
    wd = (src == 2'd0) ? 5 : (src == 2'd1) ? 14 : 24;
    if (sg && v[wd-1]) return v | (32'hFFFF_FFFF << wd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check handshake outputs against model, advance model
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    logic m_ready;
    @(negedge clk);
    if_valid = v; if_instr = w; if_pc = pc_ctr; id_ready = rdy; flush = fl;
    #1;
    m_ready = !m_halt && !fl && (!m_valid || rdy);
    chk("if_ready", 32'(if_ready), 32'(m_ready));
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("halted",   32'(halted),   32'(m_halt));
    if (fl) begin
      if (m_valid) exp_q.delete();
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (v && m_ready) begin
      exp_q.push_back(exp_of(w, pc_ctr));
      m_valid = 1'b1;
      if (w[0]) m_halt = 1'b1;
      pc_ctr = pc_ctr + 32'd4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #2;
  endtask

  // Monitor: every downstream handshake consumes one expected entry
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && id_valid && id_ready && !flush) begin
        a = '{pc: id_pc, func: id_func, rs1: id_rs1, rd: id_rd, rs2: id_rs2,
              typ: id_type, ext: ext_in, src: ext_src, sg: sign_op};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: issued pc %h with nothing expected", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", a.pc, e.pc);
          chk("sb_decode", {a.func, a.rs1, a.rd, a.rs2, a.typ, a.src, a.sg, 5'd0},
                           {e.func, e.rs1, e.rd, e.rs2, e.typ, e.src, e.sg, 5'd0});
          chk("sb_ext_in", a.ext, e.ext);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_instr(input int stop_odds);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r[31:27] = 5'd0;
    r[0] = (stop_odds > 0) && ($urandom_range(0, stop_odds - 1) == 0);
    return r;
  endfunction

  initial begin
    logic [31:0] w, pc_a;
    reset_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    flush = 1'b0; id_ready = 1'b0;
    m_valid = 1'b0; m_halt = 1'b0;
    #12 reset_n = 1'b1;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h1);
    chk("rst_halted",   32'(halted),   32'h0);
    chk("rst_id_pc",    id_pc,         32'h0);
    chk("rst_ext_in",   ext_in,        32'h0);
    chk("rst_ext_src",  32'(ext_src),  32'h0);
    chk("rst_sign_op",  32'(sign_op),  32'h1);

    // I-type immediates, signed and ANDI-unsigned
    w = {5'd1, 10'd0, 14'h2001, 2'b01, 1'b0};
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("i_ext_in", ext_in, 32'h0000_2001);
    chk("i_ext_src", 32'(ext_src), 32'h1);
    chk("i_sign_op", 32'(sign_op), 32'h1);
    chk("i_sext", sext(ext_in, ext_src, sign_op), 32'hFFFF_E001);
    w = {5'd0, 10'd0, 14'h2001, 2'b01, 1'b0};
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("andi_sign_op", 32'(sign_op), 32'h0);
    chk("andi_sext", sext(ext_in, ext_src, sign_op), 32'h0000_2001);

    // J-type and S-type
    w = {5'd2, 24'h80_0000, 2'b10, 1'b0};
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("j_ext_in", ext_in, 32'h0080_0000);
    chk("j_ext_src", 32'(ext_src), 32'h2);
    chk("j_sign_op", 32'(sign_op), 32'h1);
    w = {5'd3, 10'd0, 5'd17, 9'd0, 2'b11, 1'b0};
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("s_ext_in", ext_in, 32'h0000_0011);
    chk("s_ext_src", 32'(ext_src), 32'h0);
    chk("s_sign_op", 32'(sign_op), 32'h0);

    // Stall three cycles, then stream four back-to-back
    pc_a = pc_ctr;
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    chk("stall_pc", id_pc, pc_a);
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_instr(0), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush kills held instruction and the one presented
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Halt on stop bit, drain, then flush out of HALT
    w = rnd_instr(0) | 32'h1;
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    cycle(1'b1, rnd_instr(0), 1'b1, 1'b0);
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, rnd_instr(0), 1'b1, 1'b0);

    // Asynchronous reset mid-stream with an instruction held
    cycle(1'b1, rnd_instr(0), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_id_valid", 32'(id_valid), 32'h0);
    chk("arst_halted",   32'(halted),   32'h0);
    chk("arst_if_ready", 32'(if_ready), 32'h1);
    exp_q.delete();
    m_valid = 1'b0; m_halt = 1'b0;
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_instr(12), $urandom_range(0, 4) < 3,
            $urandom_range(0, 9) == 0);

    // Release any halt and drain
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
